instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of cpu_07_11: owns the program counter, reads the instruction ROM, and buffers fetched words in a 2-entry prefetch queue.
//  Presents opcode and operand to UnidadeControle/execute under a valid/ready handshake.
//  Accepts redirects (pc_src / jmp_uncond resolved downstream) and flushes stale prefetches.
// PARAMETERS
//  ADDR_W  4  instruction address width; PC width; operand width
//  INST_W  8  instruction word width; {opcode[7:4], operand[3:0]}
//  OPC_W   4  opcode width
// PORTS
//  clock           in   1       rising-edge clock
//  reset           in   1       asynchronous, active-high reset
//  instMemAddrBus  out  ADDR_W  ROM address (= PC)
//  instMemDataBus  in   INST_W  ROM data; combinational, valid in the same cycle as the address
//  branchTaken     in   1       redirect request (pc_src&cond | jmp_uncond)
//  branchTarget    in   ADDR_W  redirect address
//  instValid       out  1       queue head valid
//  instReady       in   1       consumer accepts head this cycle
//  opcode          out  OPC_W   head instruction [7:4]; 0 when !instValid
//  operand         out  ADDR_W  head instruction [3:0]; 0 when !instValid
//  instPc          out  ADDR_W  address of head instruction; 0 when !instValid
//  halted          out  1       HALT retired (PC_HALT_EN only; tied 0 otherwise)
// BEHAVIOUR
//  Reset (async): PC=0, queue count=0, instValid=0, opcode/operand/instPc=0, halted=0, state=RUN.
//  instMemAddrBus = PC, combinationally.
//  Each posedge in RUN: push = (count<2) | pop. On push: store {PC, instMemDataBus}; PC <= PC+1 (mod 2^ADDR_W, so F->0).
//  pop = instValid & instReady; removes head. Pop and push in the same cycle are legal when full.
//  Latency: first instruction is valid 1 cycle after reset deassertion; steady state with instReady=1 is 1 instr/cycle.
//  Backpressure: queue holds 2 entries; PC stalls while full and not popping; no entry is lost or duplicated.
//  Redirect: on branchTaken, the current pop (if any) completes, all queue entries are discarded, no push occurs, and PC <= branchTarget.
//   instValid is 0 on the next cycle; the target instruction is valid 1 cycle later (1 bubble).
//   branchTaken has priority over push.
//  branchTaken while empty: redirect only.
//  branchTaken in HALT_PEND/HALTED: ignored.
//  Reset asserted mid-operation: immediate return to reset values; in-flight entries are dropped.
//  FSM: RUN -> HALT_PEND (HALT pushed) -> HALTED (HALT popped); HALTED exits only via reset.
//   Without PC_HALT_EN, the FSM is fixed at RUN.
// CONFIGURATION
//  Macro PC_HALT_EN:
//   Defined:
//    - Opcode 4'hF is HALT. Pushing HALT stops further fetch (PC frozen at HALT addr+1; state HALT_PEND).
//    - Popping HALT sets halted=1 the next cycle (state HALTED). halted stays 1 until reset.
//    - Entries queued before HALT still drain normally.
//   Undefined:
//    - 4'hF is an ordinary opcode; halted is tied 0; fetch never stops.
// STRUCTURE
//  Package cpu_07_11_pkg:
//   - ADDR_W, INST_W, OPC_W
//   - localparam OP_HALT=4'hF
//   - typedef struct fetch_entry_t {pc, inst}
//   - enum fetch_state_t {RUN, HALT_PEND, HALTED}
//  Sub-module fetch_queue:
//   - 2-entry FIFO of fetch_entry_t; ports push, pop, flush, full, empty, head
//   - 1-bit read/write pointers, 2-bit count; flush clears count and pointers
//  Top level: PC register, push/pop/redirect arbitration, FSM.
// TESTING
//  1. ROM[i]={i,~i}; release reset with instReady=1 -> addr 0 at cycle 0; instValid=1 at cycle 1 with opcode=0, operand=F, instPc=0; one instr/cycle; PC wraps F->0.
//  2. instReady=0 for 4 cycles -> count saturates at 2; PC holds at 2; on release, instPc sequence 0,1,2,3 with no gaps or repeats.
//  3. Queue full, branchTaken=1, branchTarget=9 -> next cycle instValid=0; following cycle instPc=9; PC=A.
//  4. Pop and branchTaken in the same cycle (head pc=3, target=C) -> entry 3 consumed exactly once; next valid instPc=C.
//  5. PC_HALT_EN, ROM[5]=8'hF0 -> fetch stops with PC=6; halted=1 the cycle after instPc=5 pops; a later branchTaken is ignored.
//  6. Assert reset mid-stream with the queue holding 2 entries -> instValid=0, instMemAddrBus=0 immediately; restart matches scenario 1.

Source files
------------

// File: rtl/cpu_07_11_pkg.sv
// cpu_07_11_pkg: shared widths, HALT opcode, fetch queue entry and fetch FSM state types
package cpu_07_11_pkg;
  localparam int ADDR_W = 4;
  localparam int INST_W = 8;
  localparam int OPC_W = 4;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry prefetch FIFO of {pc, inst}; flush drops every entry
module fetch_queue
  import cpu_07_11_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);
  fetch_entry_t mem_q [2];
  logic wr_q, rd_q;
  logic [1:0] count_q;
  // pointers and occupancy; flush wins over a concurrent push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wr_q <= wr_q ^ push;
      rd_q <= rd_q ^ pop;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end
  // storage needs no reset: only slots counted as occupied are ever read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign full = count_q == 2'd2;
  assign empty = count_q == 2'd0;
  assign head = mem_q[rd_q];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, ROM fetch into a 2-entry prefetch queue, redirect flush; HALT support under PC_HALT_EN
module instr_fetch_unit
  import cpu_07_11_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] instMemAddrBus,
  input  logic [INST_W-1:0] instMemDataBus,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchTarget,
  output logic              instValid,
  input  logic              instReady,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] operand,
  output logic [ADDR_W-1:0] instPc,
  output logic              halted
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  fetch_state_t state_q, state_d;
  logic full, empty, pop, push, redirect;
  fetch_entry_t head, din;
  // arbitration: redirect beats push; a full queue may still push when popping
  always_comb begin
    redirect = branchTaken & (state_q == RUN);
    pop = instValid & instReady;
    push = (state_q == RUN) & ~redirect & (~full | pop);
    pc_d = redirect ? branchTarget : push ? pc_q + 1'b1 : pc_q;
`ifdef PC_HALT_EN
    state_d = (state_q == RUN && push && instMemDataBus[INST_W-1 -: OPC_W] == OP_HALT) ? HALT_PEND :
              (state_q == HALT_PEND && pop && head.inst[INST_W-1 -: OPC_W] == OP_HALT) ? HALTED : state_q;
`else
    state_d = RUN;
`endif
  end
  // PC and fetch state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
      state_q <= RUN;
    end else begin
      pc_q <= pc_d;
      state_q <= state_d;
    end
  end
  assign din = '{pc: pc_q, inst: instMemDataBus};
  fetch_queue u_queue (
    .clk(clock), .rst(reset), .push(push), .pop(pop), .flush(redirect),
    .din(din), .full(full), .empty(empty), .head(head)
  );
  assign instMemAddrBus = pc_q;
  assign instValid = ~empty;
  assign opcode = instValid ? head.inst[INST_W-1 -: OPC_W] : '0;
  assign operand = instValid ? head.inst[ADDR_W-1:0] : '0;
  assign instPc = instValid ? head.pc : '0;
  assign halted = state_q == HALTED;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch latency, backpressure, redirect, halt and reset
module tb_instr_fetch_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] instMemAddrBus;
  logic [7:0] instMemDataBus;
  logic branchTaken = 1'b0;
  logic [3:0] branchTarget = 4'h0;
  logic instValid;
  logic instReady = 1'b0;
  logic [3:0] opcode, operand, instPc;
  logic halted;
  logic [7:0] rom [16];
  int n_run = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  assign instMemDataBus = rom[instMemAddrBus];
  instr_fetch_unit dut (
    .clock(clock), .reset(reset), .instMemAddrBus(instMemAddrBus), .instMemDataBus(instMemDataBus),
    .branchTaken(branchTaken), .branchTarget(branchTarget), .instValid(instValid), .instReady(instReady),
    .opcode(opcode), .operand(operand), .instPc(instPc), .halted(halted)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst_valid", int'(instValid), 0);
    check("rst_addr", int'(instMemAddrBus), 0);
  endtask
  task automatic check_head(input string tag, input int pc);
    logic [7:0] w;
    w = rom[pc];
    check({tag, "_valid"}, int'(instValid), 1);
    check({tag, "_pc"}, int'(instPc), pc);
    check({tag, "_opc"}, int'(opcode), int'(w[7:4]));
    check({tag, "_opd"}, int'(operand), int'(w[3:0]));
  endtask
  task automatic stream_from_reset();
    do_reset();
    check("s1_opc_idle", int'(opcode), 0);
    check("s1_halted", int'(halted), 0);
    for (int c = 1; c <= 20; c++) begin
      step();
      check_head("s1", (c - 1) % 16);
      check("s1_addr", int'(instMemAddrBus), c % 16);
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = {i[3:0], ~i[3:0]};
`ifdef PC_HALT_EN
    rom[15] = 8'hE0;
`endif
    instReady = 1'b1;
    stream_from_reset();
    instReady = 1'b0;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      step();
      check_head("s2_stall", 0);
      check("s2_addr", int'(instMemAddrBus), c < 2 ? c : 2);
    end
    instReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_head("s2_drain", k);
      step();
    end
    instReady = 1'b0;
    do_reset();
    step();
    step();
    check("s3_addr_full", int'(instMemAddrBus), 2);
    branchTaken = 1'b1;
    branchTarget = 4'h9;
    step();
    branchTaken = 1'b0;
    check("s3_bubble", int'(instValid), 0);
    check("s3_addr_tgt", int'(instMemAddrBus), 9);
    step();
    check_head("s3_tgt", 9);
    check("s3_addr_next", int'(instMemAddrBus), 10);
    instReady = 1'b1;
    do_reset();
    for (int c = 1; c <= 4; c++) step();
    check_head("s4_head", 3);
    branchTaken = 1'b1;
    branchTarget = 4'hC;
    step();
    branchTaken = 1'b0;
    check("s4_bubble", int'(instValid), 0);
    check("s4_pc_bubble", int'(instPc), 0);
    step();
    check_head("s4_tgt", 12);
    step();
    check_head("s4_after", 13);
`ifdef PC_HALT_EN
    rom[5] = 8'hF0;
    do_reset();
    for (int c = 1; c <= 5; c++) step();
    check_head("s5_pre", 4);
    step();
    check_head("s5_halt", 5);
    check("s5_addr_frozen", int'(instMemAddrBus), 6);
    check("s5_not_yet", int'(halted), 0);
    step();
    check("s5_halted", int'(halted), 1);
    check("s5_empty", int'(instValid), 0);
    check("s5_addr_hold", int'(instMemAddrBus), 6);
    branchTaken = 1'b1;
    branchTarget = 4'h2;
    step();
    branchTaken = 1'b0;
    step();
    check("s5_br_ignored", int'(instMemAddrBus), 6);
    check("s5_still_halted", int'(halted), 1);
    check("s5_still_empty", int'(instValid), 0);
    rom[5] = {4'h5, 4'hA};
`endif
    instReady = 1'b0;
    do_reset();
    for (int c = 1; c <= 3; c++) step();
    check_head("s6_full", 0);
    check("s6_addr_full", int'(instMemAddrBus), 2);
    #2;
    reset = 1'b1;
    #1;
    check("s6_async_valid", int'(instValid), 0);
    check("s6_async_addr", int'(instMemAddrBus), 0);
    check("s6_async_pc", int'(instPc), 0);
    instReady = 1'b1;
    stream_from_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
